// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Single-issue instruction fetch stage. Holds the fetch PC, issues one request
// at a time to instruction memory over a req/ack handshake, and captures the
// returned word into an instruction register. Decode (and the immediate
// extender via instr_o[31:7]) sees the held instruction together with its
// address and address+4. Redirects from execute arrive on pcsrc_i/pctarget_i;
// flush_i discards whatever is in flight and refetches from pctarget_i.
//
// Ports
//   clk_i          rising-edge clock
//   rst_n_i        asynchronous active-low reset
//   stall_i        decode not ready: hold the delivered instruction
//   pcsrc_i        take redirect to pctarget_i when the instruction is consumed
//   pctarget_i     redirect / flush target address
//   flush_i        drop in-flight fetch or held instruction, refetch target
//   imem_req_o     fetch request (held until ack)
//   imem_addr_o    fetch address, stable while a request is outstanding
//   imem_ack_i     memory response valid (one cycle per request)
//   imem_rdata_i   returned instruction word
//   instr_o        held instruction (NOP_INSTR when nothing valid)
//   instr_valid_o  instr_o is a real instruction
//   pc_o           address of instr_o
//   pcplus4_o      pc_o + 4 (wraps modulo 2^32)
//   misalign_o     sticky misaligned-target flag
//
// Build option
//   MISALIGN_TRAP_EN  when defined, a misaligned redirect/flush target sets
//                     misalign_o and parks the stage in HALT until reset.
//                     When undefined, target bits [1:0] are cleared on load
//                     and misalign_o is constant 0.
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        stall_i,
    input  logic        pcsrc_i,
    input  logic [31:0] pctarget_i,
    input  logic        flush_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic        instr_valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] pcplus4_o,
    output logic        misalign_o
);

`ifdef MISALIGN_TRAP_EN
    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DELIVER = 2'd1,
        HALT    = 2'd2
    } state_e;
`else
    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DELIVER = 2'd1
    } state_e;
`endif

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;          // address of the next instruction to fetch
    logic [31:0] addr_q, addr_d;      // address presented to memory
    logic        req_q, req_d;
    logic        kill_q, kill_d;      // outstanding request's data must be dropped
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic [31:0] pco_q, pco_d;
    logic [31:0] pcp4_q, pcp4_d;

    logic [31:0] target;
    logic [31:0] seq_pc;
    logic        fetch_ack;

`ifdef MISALIGN_TRAP_EN
    logic        misalign_q, misalign_d;
    logic        takes_target;
    logic        trap;

    // Raw target is kept so the offending address is visible in pc_q.
    assign target = pctarget_i;

    // Any path that loads pctarget_i into pc_q this cycle.
    assign takes_target = ((state_q == FETCH) && flush_i) ||
                          ((state_q == DELIVER) && (flush_i || (!stall_i && pcsrc_i)));
    assign trap         = takes_target && (pctarget_i[1:0] != 2'b00);
`else
    function automatic logic [31:0] align_target(input logic [31:0] t);
        return t & 32'hFFFF_FFFC;
    endfunction

    assign target = align_target(pctarget_i);
`endif

    assign seq_pc = pc_q + 32'd4;

    // req_q is only ever set while in FETCH, so it also marks the state.
    assign fetch_ack = req_q && imem_ack_i;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        kill_d  = kill_q;
        instr_d = instr_q;
        valid_d = valid_q;
        pco_d   = pco_q;
        pcp4_d  = pcp4_q;
`ifdef MISALIGN_TRAP_EN
        misalign_d = misalign_q;
`endif

        case (state_q)
            FETCH: begin
                if (flush_i) begin
                    // The memory transaction runs to completion; if it has not
                    // returned yet its data is marked for discard. A flush that
                    // coincides with the ack simply drops that data.
                    pc_d   = target;
                    kill_d = req_q && !imem_ack_i;
                end else if (fetch_ack) begin
                    if (kill_q) begin
                        kill_d = 1'b0;
                    end else begin
                        instr_d = imem_rdata_i;
                        pco_d   = pc_q;
                        pcp4_d  = seq_pc;
                        valid_d = 1'b1;
                        state_d = DELIVER;
                    end
                end
            end

            DELIVER: begin
                if (flush_i || !stall_i) begin
                    state_d = FETCH;
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                    if (flush_i || pcsrc_i) begin
                        pc_d = target;
                    end else begin
                        pc_d = seq_pc;
                    end
                end
            end

`ifdef MISALIGN_TRAP_EN
            HALT: begin
                state_d = HALT;
            end
`endif

            default: begin
                state_d = FETCH;
            end
        endcase

`ifdef MISALIGN_TRAP_EN
        if (trap) begin
            state_d    = HALT;
            misalign_d = 1'b1;
            kill_d     = 1'b0;
            valid_d    = 1'b0;
            instr_d    = NOP_INSTR;
        end
`endif

        req_d = (state_d == FETCH);

        // Freeze the bus address while a request is outstanding so a flush
        // never disturbs the transaction; otherwise track the next PC.
        if (req_q && !imem_ack_i) begin
            addr_d = addr_q;
        end else begin
            addr_d = pc_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            req_q   <= 1'b0;
            kill_q  <= 1'b0;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            pco_q   <= RESET_PC;
            pcp4_q  <= RESET_PC + 32'd4;
`ifdef MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            kill_q  <= kill_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            pco_q   <= pco_d;
            pcp4_q  <= pcp4_d;
`ifdef MISALIGN_TRAP_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    assign imem_req_o    = req_q;
    assign imem_addr_o   = addr_q;
    assign instr_o       = instr_q;
    assign instr_valid_o = valid_q;
    assign pc_o          = pco_q;
    assign pcplus4_o     = pcp4_q;
`ifdef MISALIGN_TRAP_EN
    assign misalign_o    = misalign_q;
`else
    assign misalign_o    = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
`timescale 1ns/1ps
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk_i        = 1'b0;
    logic        rst_n_i      = 1'b1;
    logic        stall_i      = 1'b0;
    logic        pcsrc_i      = 1'b0;
    logic [31:0] pctarget_i   = 32'h0;
    logic        flush_i      = 1'b0;
    logic        imem_ack_i   = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] instr_o;
    logic        instr_valid_o;
    logic [31:0] pc_o;
    logic [31:0] pcplus4_o;
    logic        misalign_o;

    int checks = 0;
    int errors = 0;
    int mem_lat = 0;   // negative: random 0..3 wait cycles per request
    int wait_cnt = 0;
    int cur_lat = 0;

    instr_fetch #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .stall_i(stall_i), .pcsrc_i(pcsrc_i),
        .pctarget_i(pctarget_i), .flush_i(flush_i), .imem_req_o(imem_req_o),
        .imem_addr_o(imem_addr_o), .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
        .instr_o(instr_o), .instr_valid_o(instr_valid_o), .pc_o(pc_o),
        .pcplus4_o(pcplus4_o), .misalign_o(misalign_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
    endfunction

    // Memory: acks each request after cur_lat waiting cycles, one cycle per ack.
    always @(negedge clk_i) begin
        #1;
        if (imem_ack_i) begin
            imem_ack_i = 1'b0;
            wait_cnt = 0;
        end
        if (rst_n_i && imem_req_o) begin
            if (wait_cnt == 0) cur_lat = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
            if (wait_cnt >= cur_lat) begin
                imem_ack_i   = 1'b1;
                imem_rdata_i = mem_word(imem_addr_o);
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic apply_reset();
        @(negedge clk_i);
        rst_n_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0; pcsrc_i = 1'b0; pctarget_i = 32'h0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        int n;
        n = 0;
        ok = 1'b0;
        while (n < budget) begin
            if (instr_valid_o) begin
                ok = 1'b1;
                break;
            end
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        #2 rst_n_i = 1'b0;
        #1;
        checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", imem_req_o); end
        checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", instr_valid_o); end
        checks++; if (instr_o !== NOP) begin errors++; $display("FAIL reset_instr got %h want %h", instr_o, NOP); end
        checks++; if (pc_o !== RESET_PC) begin errors++; $display("FAIL reset_pc got %h want %h", pc_o, RESET_PC); end
        checks++; if (pcplus4_o !== RESET_PC + 32'd4) begin errors++; $display("FAIL reset_pcplus4 got %h want %h", pcplus4_o, RESET_PC + 32'd4); end
        checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b want 0", misalign_o); end
        checks++; if (imem_addr_o !== RESET_PC) begin errors++; $display("FAIL reset_addr got %h want %h", imem_addr_o, RESET_PC); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        int last_v;
        int seen;
        exp_pc = RESET_PC; last_v = -1; seen = 0;
        mem_lat = 0;
        apply_reset();
        for (int cyc = 0; cyc < 40 && seen < 3; cyc++) begin
            step();
            if (imem_req_o) begin
                checks++; if (imem_addr_o !== exp_pc) begin errors++; $display("FAIL seq_addr got %h want %h", imem_addr_o, exp_pc); end
            end
            if (instr_valid_o) begin
                checks++; if (pc_o !== exp_pc) begin errors++; $display("FAIL seq_pc got %h want %h", pc_o, exp_pc); end
                checks++; if (pcplus4_o !== exp_pc + 32'd4) begin errors++; $display("FAIL seq_pcplus4 got %h want %h", pcplus4_o, exp_pc + 32'd4); end
                checks++; if (instr_o !== mem_word(exp_pc)) begin errors++; $display("FAIL seq_instr got %h want %h", instr_o, mem_word(exp_pc)); end
                if (last_v >= 0) begin
                    checks++; if (cyc - last_v != 2) begin errors++; $display("FAIL seq_spacing got %0d want 2", cyc - last_v); end
                end
                last_v = cyc;
                exp_pc = exp_pc + 32'd4;
                seen++;
            end
        end
        checks++; if (seen != 3) begin errors++; $display("FAIL seq_count got %0d want 3", seen); end
    endtask

    task automatic test_stall();
        bit ok;
        mem_lat = 0;
        apply_reset();
        wait_valid(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stall_timeout got no valid want valid"); end
        checks++; if (instr_o !== 32'h0050_0093) begin errors++; $display("FAIL stall_first_instr got %h want 00500093", instr_o); end
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (instr_valid_o !== 1'b1) begin errors++; $display("FAIL stall_valid got %b want 1", instr_valid_o); end
            checks++; if (instr_o !== 32'h0050_0093) begin errors++; $display("FAIL stall_instr got %h want 00500093", instr_o); end
            checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL stall_pc got %h want 0", pc_o); end
            checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL stall_req got %b want 0", imem_req_o); end
        end
        stall_i = 1'b0;
        step();
        checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL stall_rel_valid got %b want 0", instr_valid_o); end
        checks++; if (instr_o !== NOP) begin errors++; $display("FAIL stall_rel_nop got %h want %h", instr_o, NOP); end
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h4) begin errors++; $display("FAIL stall_next_fetch got req=%b addr=%h want req=1 addr=4", imem_req_o, imem_addr_o); end
    endtask

    task automatic test_branch();
        bit ok;
        mem_lat = 0;
        apply_reset();
        wait_valid(20, ok);
        pcsrc_i = 1'b1; pctarget_i = 32'h0000_0100;
        step();
        pcsrc_i = 1'b0;
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin errors++; $display("FAIL branch_addr got req=%b addr=%h want req=1 addr=100", imem_req_o, imem_addr_o); end
        wait_valid(20, ok);
        checks++; if (!ok || pc_o !== 32'h100) begin errors++; $display("FAIL branch_pc got ok=%b pc=%h want pc=100", ok, pc_o); end
        checks++; if (pcplus4_o !== 32'h104) begin errors++; $display("FAIL branch_pcplus4 got %h want 104", pcplus4_o); end
        checks++; if (instr_o !== mem_word(32'h100)) begin errors++; $display("FAIL branch_instr got %h want %h", instr_o, mem_word(32'h100)); end
    endtask

    task automatic test_flush_fetch();
        bit ok;
        bit saw_target;
        mem_lat = 4;
        apply_reset();
        step();
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin errors++; $display("FAIL fflush_req got req=%b addr=%h want req=1 addr=0", imem_req_o, imem_addr_o); end
        step();
        flush_i = 1'b1; pctarget_i = 32'h0000_0200;
        step();
        flush_i = 1'b0;
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin errors++; $display("FAIL fflush_hold got req=%b addr=%h want req=1 addr=0", imem_req_o, imem_addr_o); end
        saw_target = 1'b0;
        for (int i = 0; i < 30 && !instr_valid_o; i++) begin
            if (imem_req_o && imem_addr_o == 32'h200) saw_target = 1'b1;
            step();
        end
        checks++; if (instr_valid_o !== 1'b1) begin errors++; $display("FAIL fflush_timeout got valid=%b want 1", instr_valid_o); end
        checks++; if (pc_o !== 32'h200) begin errors++; $display("FAIL fflush_pc got %h want 200", pc_o); end
        checks++; if (instr_o !== mem_word(32'h200)) begin errors++; $display("FAIL fflush_instr got %h want %h", instr_o, mem_word(32'h200)); end
        checks++; if (!saw_target) begin errors++; $display("FAIL fflush_refetch got none want request to 200"); end
        mem_lat = 0;
    endtask

    task automatic test_flush_ack();
        bit ok;
        mem_lat = 0;
        apply_reset();
        step();
        flush_i = 1'b1; pctarget_i = 32'h0000_0300;
        step();
        flush_i = 1'b0;
        checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL flushack_valid got %b want 0", instr_valid_o); end
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h300) begin errors++; $display("FAIL flushack_addr got req=%b addr=%h want req=1 addr=300", imem_req_o, imem_addr_o); end
        wait_valid(20, ok);
        checks++; if (!ok || pc_o !== 32'h300) begin errors++; $display("FAIL flushack_pc got ok=%b pc=%h want 300", ok, pc_o); end
    endtask

    task automatic test_flush_deliver();
        bit ok;
        mem_lat = 0;
        apply_reset();
        wait_valid(20, ok);
        stall_i = 1'b1; flush_i = 1'b1; pctarget_i = 32'h0000_0400;
        step();
        stall_i = 1'b0; flush_i = 1'b0;
        checks++; if (instr_valid_o !== 1'b0 || instr_o !== NOP) begin errors++; $display("FAIL dflush_drop got valid=%b instr=%h want valid=0 instr=%h", instr_valid_o, instr_o, NOP); end
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h400) begin errors++; $display("FAIL dflush_addr got req=%b addr=%h want req=1 addr=400", imem_req_o, imem_addr_o); end
        wait_valid(20, ok);
        checks++; if (!ok || pc_o !== 32'h400) begin errors++; $display("FAIL dflush_pc got ok=%b pc=%h want 400", ok, pc_o); end
    endtask

    task automatic test_wrap();
        bit ok;
        mem_lat = 0;
        apply_reset();
        wait_valid(20, ok);
        pcsrc_i = 1'b1; pctarget_i = 32'hFFFF_FFFC;
        step();
        pcsrc_i = 1'b0;
        wait_valid(20, ok);
        checks++; if (!ok || pc_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc got ok=%b pc=%h want fffffffc", ok, pc_o); end
        checks++; if (pcplus4_o !== 32'h0) begin errors++; $display("FAIL wrap_pcplus4 got %h want 0", pcplus4_o); end
        step();
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin errors++; $display("FAIL wrap_addr got req=%b addr=%h want req=1 addr=0", imem_req_o, imem_addr_o); end
        wait_valid(20, ok);
        checks++; if (!ok || pc_o !== 32'h0 || pcplus4_o !== 32'h4) begin errors++; $display("FAIL wrap_next got pc=%h pcplus4=%h want 0/4", pc_o, pcplus4_o); end
    endtask

    task automatic test_misalign();
        bit ok;
        mem_lat = 0;
        apply_reset();
        wait_valid(20, ok);
        pcsrc_i = 1'b1; pctarget_i = 32'h0000_0102;
        step();
        pcsrc_i = 1'b0;
`ifdef MISALIGN_TRAP_EN
        for (int i = 0; i < 5; i++) begin
            checks++; if (misalign_o !== 1'b1) begin errors++; $display("FAIL mis_flag got %b want 1", misalign_o); end
            checks++; if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0) begin errors++; $display("FAIL mis_halt got req=%b valid=%b want 0/0", imem_req_o, instr_valid_o); end
            step();
        end
        rst_n_i = 1'b0;
        #1;
        checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL mis_clear got %b want 0", misalign_o); end
        @(negedge clk_i);
        rst_n_i = 1'b1;
        step();
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== RESET_PC) begin errors++; $display("FAIL mis_restart got req=%b addr=%h want req=1 addr=%h", imem_req_o, imem_addr_o, RESET_PC); end
`else
        checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL mis_flag got %b want 0", misalign_o); end
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin errors++; $display("FAIL mis_align got req=%b addr=%h want req=1 addr=100", imem_req_o, imem_addr_o); end
        wait_valid(20, ok);
        checks++; if (!ok || pc_o !== 32'h100) begin errors++; $display("FAIL mis_pc got ok=%b pc=%h want 100", ok, pc_o); end
`endif
    endtask

    task automatic test_async_reset();
        bit ok;
        mem_lat = 6;
        apply_reset();
        step();
        step();
        checks++; if (imem_req_o !== 1'b1) begin errors++; $display("FAIL areset_pre got req=%b want 1", imem_req_o); end
        #2 rst_n_i = 1'b0;
        #1;
        checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL areset_req got %b want 0", imem_req_o); end
        checks++; if (instr_valid_o !== 1'b0 || pc_o !== RESET_PC) begin errors++; $display("FAIL areset_state got valid=%b pc=%h want 0/%h", instr_valid_o, pc_o, RESET_PC); end
        @(negedge clk_i);
        mem_lat = 0;
        rst_n_i = 1'b1;
        step();
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== RESET_PC) begin errors++; $display("FAIL areset_restart got req=%b addr=%h want req=1 addr=%h", imem_req_o, imem_addr_o, RESET_PC); end
        wait_valid(20, ok);
        checks++; if (!ok || pc_o !== RESET_PC || instr_o !== mem_word(RESET_PC)) begin errors++; $display("FAIL areset_first got pc=%h instr=%h want %h/%h", pc_o, instr_o, RESET_PC, mem_word(RESET_PC)); end
    endtask

    // Reference model: exp_pc is the address of the next instruction decode
    // should receive, advanced only by consumption, redirects and flushes.
    task automatic test_random();
        logic [31:0] exp_pc;
        bit prev_v;
        bit clean;
        int idle;
        int delivered;
        exp_pc = RESET_PC; prev_v = 1'b0; clean = 1'b1; idle = 0; delivered = 0;
        mem_lat = -1;
        apply_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            step();
            if (instr_valid_o && !prev_v) begin
                checks++; if (pc_o !== exp_pc) begin errors++; $display("FAIL rand_pc got %h want %h", pc_o, exp_pc); end
                checks++; if (instr_o !== mem_word(exp_pc)) begin errors++; $display("FAIL rand_instr got %h want %h", instr_o, mem_word(exp_pc)); end
                checks++; if (pcplus4_o !== exp_pc + 32'd4) begin errors++; $display("FAIL rand_pcplus4 got %h want %h", pcplus4_o, exp_pc + 32'd4); end
                delivered++;
                clean = 1'b1;
                idle = 0;
            end
            if (imem_req_o && clean) begin
                checks++; if (imem_addr_o !== exp_pc) begin errors++; $display("FAIL rand_addr got %h want %h", imem_addr_o, exp_pc); end
            end
            idle++;
            if (idle > 80) begin
                checks++; errors++; $display("FAIL rand_progress got no delivery in 80 cycles want delivery");
                break;
            end
            prev_v = instr_valid_o;
            stall_i    = ($urandom_range(0, 2) == 0);
            flush_i    = ($urandom_range(0, 11) == 0);
            pcsrc_i    = ($urandom_range(0, 3) == 0);
            pctarget_i = 32'($urandom_range(0, 255)) << 2;
            if (flush_i) begin
                exp_pc = pctarget_i;
                clean = 1'b0;
            end else if (instr_valid_o && !stall_i) begin
                exp_pc = pcsrc_i ? pctarget_i : exp_pc + 32'd4;
            end
        end
        stall_i = 1'b0; flush_i = 1'b0; pcsrc_i = 1'b0;
        checks++; if (delivered < 50) begin errors++; $display("FAIL rand_deliveries got %0d want >=50", delivered); end
        mem_lat = 0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_flush_fetch();
        test_flush_ack();
        test_flush_deliver();
        test_wrap();
        test_misalign();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
